// File: rtl/pattern_sequencer.sv
// Plays a programmed list of {ontime, offtime, reps} steps into one blink-pattern
// generator. It waits for the generator's done after each step and inserts an enable-low gap.
module pattern_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int GAP   = 2
) (
    input  logic          hwclk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_ontime,
    input  logic [31:0]   wr_offtime,
    input  logic [7:0]    wr_reps,
    input  logic [AW:0]   len,
    input  logic          loop,
    input  logic          start,
    input  logic          abort,
    input  logic          pat_done,
    output logic [31:0]   ontime,
    output logic [31:0]   offtime,
    output logic [7:0]    reps,
    output logic          pat_enable,
    output logic [AW-1:0] step_idx,
    output logic          busy,
    output logic          seq_done,
    output logic          err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;

    localparam int          GW      = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [AW:0] LEN_MAX = (AW + 1)'(DEPTH);

    logic [2:0]    state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] step_q, step_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          seqDone_q, seqDone_d;
    logic          err_q, err_d;
    logic [AW:0]   stepNext;

    logic [31:0]   tabOn_q   [DEPTH];
    logic [31:0]   tabOff_q  [DEPTH];
    logic [7:0]    tabReps_q [DEPTH];
    logic [31:0]   onTime_q, offTime_q;
    logic [7:0]    reps_q;

    // One bit wider than the index so the last step cannot wrap before the compare.
    assign stepNext = {1'b0, step_q} + (AW + 1)'(1);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        step_d    = step_q;
        gap_d     = gap_q;
        seqDone_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len == '0 || len > LEN_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = len;
                        step_d  = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: state_d = S_RUN;
            S_RUN: begin
                if (pat_done) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_CLEAR;
                else                   gap_d   = gap_q + 1'b1;
            end
            S_CLEAR: begin
                if (!pat_done) begin
                    if (stepNext < len_q) begin
                        step_d  = stepNext[AW-1:0];
                        state_d = S_LOAD;
                    end else if (loop) begin
                        step_d  = '0;
                        state_d = S_LOAD;
                    end else begin
                        seqDone_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort wins over start and pat_done, and never reports completion.
        if (abort) begin
            state_d   = S_IDLE;
            step_d    = (state_q == S_IDLE) ? step_q : '0;
            seqDone_d = 1'b0;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            step_q    <= '0;
            gap_q     <= '0;
            seqDone_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            step_q    <= step_d;
            gap_q     <= gap_d;
            seqDone_q <= seqDone_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tabOn_q[i]   <= '0;
                tabOff_q[i]  <= '0;
                tabReps_q[i] <= '0;
            end
            onTime_q  <= '0;
            offTime_q <= '0;
            reps_q    <= '0;
        end else begin
            if (wr_en && state_q == S_IDLE) begin
                tabOn_q[wr_addr]   <= wr_ontime;
                tabOff_q[wr_addr]  <= wr_offtime;
                tabReps_q[wr_addr] <= wr_reps;
            end
            // Generator parameters move only here, so they hold steady throughout RUN.
            if (state_q == S_LOAD) begin
                onTime_q  <= tabOn_q[step_q];
                offTime_q <= tabOff_q[step_q];
                reps_q    <= tabReps_q[step_q];
            end
        end
    end

    assign ontime     = onTime_q;
    assign offtime    = offTime_q;
    assign reps       = reps_q;
    assign pat_enable = (state_q == S_RUN);
    assign step_idx   = step_q;
    assign busy       = (state_q != S_IDLE);
    assign seq_done   = seqDone_q;
    assign err        = err_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: a behavioural generator answers pat_enable with pat_done,
// and a scoreboard of expected steps is checked each time a step starts running.
module tb_pattern_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int GAP   = 2;

    logic          hwclk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_ontime, wr_offtime;
    logic [7:0]    wr_reps;
    logic [AW:0]   len;
    logic          loop, start, abort, pat_done;
    logic [31:0]   ontime, offtime;
    logic [7:0]    reps;
    logic          pat_enable, busy, seq_done, err;
    logic [AW-1:0] step_idx;

    typedef struct packed {
        logic [31:0] stepIdx;
        logic [31:0] on;
        logic [31:0] off;
        logic [7:0]  reps;
        logic [31:0] runLen;
        logic [31:0] gapExp;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [31:0] mOn [DEPTH];
    logic [31:0] mOff[DEPTH];
    logic [7:0]  mReps[DEPTH];
    int          checkCount = 0;
    int          failCount  = 0;
    int          doneCount  = 0;
    int          errCount   = 0;
    int          doneBase;
    int          errBase;
    logic        abortFlag  = 1'b0;

    pattern_sequencer #(.DEPTH(DEPTH), .AW(AW), .GAP(GAP)) dut (
        .hwclk(hwclk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_ontime(wr_ontime), .wr_offtime(wr_offtime), .wr_reps(wr_reps),
        .len(len), .loop(loop), .start(start), .abort(abort), .pat_done(pat_done),
        .ontime(ontime), .offtime(offtime), .reps(reps), .pat_enable(pat_enable),
        .step_idx(step_idx), .busy(busy), .seq_done(seq_done), .err(err)
    );

    always #5 hwclk = ~hwclk;

    // Single comparison point; every check is counted here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int calcRun(input logic [31:0] on, input logic [31:0] off,
                                   input logic [7:0] r);
        int v;
        v = (int'(on) + int'(off)) * int'({24'b0, r});
        return (v < 1) ? 1 : v;
    endfunction

    task automatic tick;
        @(posedge hwclk);
        #1;
    endtask

    task automatic writeEntry(input int a, input int on, input int off, input int r);
        wr_en      = 1'b1;
        wr_addr    = AW'(a);
        wr_ontime  = 32'(on);
        wr_offtime = 32'(off);
        wr_reps    = 8'(r);
        mOn[a] = 32'(on); mOff[a] = 32'(off); mReps[a] = 8'(r);
        tick;
        wr_en = 1'b0;
    endtask

    // Queue the expected steps from the model table, then pulse start for one edge.
    task automatic applyStimulus(input int lenVal, input logic loopVal, input int passes);
        exp_t e;
        for (int p = 0; p < passes; p++) begin
            for (int s = 0; s < lenVal; s++) begin
                e.stepIdx = 32'(s);
                e.on      = mOn[s];
                e.off     = mOff[s];
                e.reps    = mReps[s];
                e.runLen  = 32'(calcRun(mOn[s], mOff[s], mReps[s]));
                e.gapExp  = (p == 0 && s == 0) ? 32'd0 : 32'(GAP + 2);
                sb.push_back(e);
            end
        end
        len   = (AW + 1)'(lenVal);
        loop  = loopVal;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic rejectStart(input int lenVal);
        len   = (AW + 1)'(lenVal);
        start = 1'b1;
        tick;
        start = 1'b0;
        checkOutput("errPulse", 32'(err), 32'd1);
        checkOutput("errBusy", 32'(busy), 32'd0);
        tick;
        checkOutput("errClear", 32'(err), 32'd0);
    endtask

    task automatic waitIdle;
        int n;
        n = 0;
        while (busy && n < 1000) begin
            tick;
            n++;
        end
        if (busy) checkOutput("idleTimeout", 32'(busy), 32'd0);
        tick;
    endtask

    task automatic waitRun(input int stepVal);
        int n;
        n = 0;
        while (!(pat_enable && int'(step_idx) == stepVal) && n < 1000) begin
            tick;
            n++;
        end
        if (n >= 1000) checkOutput("runTimeout", 32'(pat_enable), 32'd1);
    endtask

    // Behavioural generator: done after the computed run length, cleared while enable is low.
    initial begin
        int genCnt;
        pat_done = 1'b0;
        genCnt   = 0;
        forever begin
            @(negedge hwclk);
            if (!pat_enable) begin
                pat_done = 1'b0;
                genCnt   = 0;
            end else if (!pat_done) begin
                genCnt++;
                if (genCnt >= calcRun(ontime, offtime, reps)) pat_done = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each enable rise and checks runs, gaps and pulses.
    initial begin
        logic prevEn;
        logic haveCur;
        int   runCount;
        int   lowCount;
        prevEn = 1'b0; haveCur = 1'b0; runCount = 0; lowCount = 0;
        forever begin
            @(negedge hwclk);
            if (rst) begin
                prevEn  = 1'b0;
                haveCur = 1'b0;
            end else begin
                if (seq_done) begin
                    doneCount++;
                    checkOutput("busyAtDone", 32'(busy), 32'd0);
                end
                if (err) errCount++;
                if (pat_enable && !prevEn) begin
                    if (sb.size() == 0) begin
                        checkOutput("sbHasEntry", 32'(sb.size()), 32'd1);
                    end else begin
                        cur = sb.pop_front();
                        haveCur  = 1'b1;
                        runCount = 0;
                        checkOutput("stepIdx", 32'(step_idx), cur.stepIdx);
                        checkOutput("ontime", ontime, cur.on);
                        checkOutput("offtime", offtime, cur.off);
                        checkOutput("reps", 32'(reps), 32'(cur.reps));
                        if (cur.gapExp != 0) checkOutput("gapLow", 32'(lowCount), cur.gapExp);
                    end
                end
                if (pat_enable && haveCur) begin
                    runCount++;
                    checkOutput("paramStable",
                        32'(ontime == cur.on && offtime == cur.off && reps == cur.reps), 32'd1);
                end
                if (!pat_enable && prevEn) begin
                    if (haveCur && !abortFlag) checkOutput("runLen", 32'(runCount), cur.runLen);
                    haveCur  = 1'b0;
                    lowCount = 0;
                end
                if (!pat_enable) lowCount++;
                prevEn = pat_enable;
            end
        end
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_ontime = '0; wr_offtime = '0;
        wr_reps = '0; len = '0; loop = 1'b0; start = 1'b0; abort = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mOn[i] = '0; mOff[i] = '0; mReps[i] = '0;
        end
        #12;
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstEnable", 32'(pat_enable), 32'd0);
        checkOutput("rstStep", 32'(step_idx), 32'd0);
        checkOutput("rstOntime", ontime, 32'd0);
        checkOutput("rstSeqDone", 32'(seq_done), 32'd0);
        checkOutput("rstErr", 32'(err), 32'd0);
        rst = 1'b0;
        tick;

        $display("[TB] single step");
        writeEntry(0, 3, 2, 2);
        doneBase = doneCount;
        applyStimulus(1, 1'b0, 1);
        checkOutput("loadBusy", 32'(busy), 32'd1);
        checkOutput("loadEnable", 32'(pat_enable), 32'd0);
        tick;
        checkOutput("runEnable", 32'(pat_enable), 32'd1);
        waitIdle;
        checkOutput("singleDone", 32'(doneCount - doneBase), 32'd1);
        checkOutput("singleSbEmpty", 32'(sb.size()), 32'd0);

        $display("[TB] three steps, entry 0 written with start");
        writeEntry(1, 2, 2, 1);
        writeEntry(2, 4, 1, 3);
        wr_en = 1'b1; wr_addr = '0; wr_ontime = 32'd1; wr_offtime = 32'd1; wr_reps = 8'd1;
        mOn[0] = 32'd1; mOff[0] = 32'd1; mReps[0] = 8'd1;
        doneBase = doneCount;
        applyStimulus(3, 1'b0, 1);
        wr_en = 1'b0;
        waitIdle;
        checkOutput("threeDone", 32'(doneCount - doneBase), 32'd1);
        checkOutput("threeSbEmpty", 32'(sb.size()), 32'd0);

        $display("[TB] loop");
        doneBase = doneCount;
        applyStimulus(2, 1'b1, 3);
        begin
            int n;
            n = 0;
            while (sb.size() > 1 && n < 1000) begin
                tick;
                n++;
            end
            if (n >= 1000) checkOutput("loopTimeout", 32'(sb.size()), 32'd1);
        end
        checkOutput("loopNoDone", 32'(doneCount - doneBase), 32'd0);
        loop = 1'b0;
        waitIdle;
        checkOutput("loopDone", 32'(doneCount - doneBase), 32'd1);
        checkOutput("loopSbEmpty", 32'(sb.size()), 32'd0);

        $display("[TB] abort during step 1");
        doneBase = doneCount;
        applyStimulus(3, 1'b0, 1);
        waitRun(1);
        abortFlag = 1'b1;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortEnable", 32'(pat_enable), 32'd0);
        checkOutput("abortStep", 32'(step_idx), 32'd0);
        tick; tick; tick;
        checkOutput("abortNoDone", 32'(doneCount - doneBase), 32'd0);
        sb.delete();
        abortFlag = 1'b0;
        applyStimulus(1, 1'b0, 1);
        waitIdle;
        checkOutput("restartDone", 32'(doneCount - doneBase), 32'd1);

        $display("[TB] illegal start and write while busy");
        errBase = errCount;
        rejectStart(0);
        rejectStart(DEPTH + 1);
        checkOutput("errCount", 32'(errCount - errBase), 32'd2);
        applyStimulus(1, 1'b0, 1);
        wr_en = 1'b1; wr_addr = '0; wr_ontime = 32'd9; wr_offtime = 32'd9; wr_reps = 8'd9;
        tick;
        wr_en = 1'b0;
        waitIdle;
        applyStimulus(1, 1'b0, 1);
        waitIdle;
        checkOutput("replaySbEmpty", 32'(sb.size()), 32'd0);

        $display("[TB] async reset mid-gap");
        applyStimulus(3, 1'b0, 1);
        waitRun(0);
        begin
            int n;
            n = 0;
            while (pat_enable && n < 1000) begin
                tick;
                n++;
            end
        end
        abortFlag = 1'b1;
        #2 rst = 1'b1;
        #1;
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstEnable", 32'(pat_enable), 32'd0);
        checkOutput("midRstStep", 32'(step_idx), 32'd0);
        checkOutput("midRstOntime", ontime, 32'd0);
        checkOutput("midRstOfftime", offtime, 32'd0);
        checkOutput("midRstReps", 32'(reps), 32'd0);
        checkOutput("midRstSeqDone", 32'(seq_done), 32'd0);
        sb.delete();
        for (int i = 0; i < DEPTH; i++) begin
            mOn[i] = '0; mOff[i] = '0; mReps[i] = '0;
        end
        #10 rst = 1'b0;
        tick;
        abortFlag = 1'b0;
        doneBase = doneCount;
        applyStimulus(2, 1'b0, 1);
        waitIdle;
        checkOutput("zeroDone", 32'(doneCount - doneBase), 32'd1);
        checkOutput("zeroSbEmpty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
